// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// latched instruction classes and ALU-op codes.
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } ctrl_state_t;

  // Branch flavour is folded into the class so EXEC needs no live funct3.
  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BEQ, C_BNE, C_BNOP
  } instr_class_t;

  function automatic instr_class_t decode_class(input logic [6:0] op,
                                                input logic [2:0] f3);
    instr_class_t c;
    c = C_NONE;
    case (op)
      OP_R:      c = C_R;
      OP_I:      c = C_I;
      OP_LOAD:   c = C_LOAD;
      OP_STORE:  c = C_STORE;
      OP_BRANCH: begin
        if (f3 == F3_BEQ)      c = C_BEQ;
        else if (f3 == F3_BNE) c = C_BNE;
        else                   c = C_BNOP;
      end
      default:   c = C_NONE;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared-memory handshake between the controller and the memory port.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/perf_counter.sv
// Free-running event counter with enable; wraps naturally at 2^W.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = en ? cnt_q + {{(W-1){1'b0}}, 1'b1} : cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB plus an absorbing
// TRAP for unsupported opcodes, with a retired-instruction counter.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     zero,
  multicycle_ctrl_if.master        mem,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic                     pc_br,
  output logic                     alu_src,
  output logic [1:0]               alu_op,
  output logic                     reg_we,
  output logic                     mem_to_reg,
  output logic                     retire,
  output logic                     illegal,
  output logic [31:0]              retire_cnt
);
  ctrl_state_t  state_q, state_d;
  instr_class_t class_q, class_d;
  logic         mem_req, mem_we, addr_sel, rdy, is_br;

  assign rdy   = mem.mem_ready;
  assign is_br = (class_q == C_BEQ) || (class_q == C_BNE) || (class_q == C_BNOP);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        class_d = decode_class(opcode, funct3);
        state_d = (class_d == C_NONE) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (class_q)
          C_R, C_I:         state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (rdy) state_d = (class_q == C_STORE) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_FETCH;
      class_q <= C_NONE;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  // Strobes are gated by n_rst so an asserted reset silences everything
  // at once, even while the state register sits in FETCH.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_br      = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    if (n_rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = rdy;
          pc_we   = rdy;
        end
        S_EXEC: begin
          case (class_q)
            C_R:             begin alu_src = 1'b0; alu_op = ALU_FUNCT; end
            C_I:             begin alu_src = 1'b1; alu_op = ALU_FUNCT; end
            C_LOAD, C_STORE: begin alu_src = 1'b1; alu_op = ALU_ADD;   end
            default:         begin alu_src = 1'b0; alu_op = ALU_SUB;   end
          endcase
          pc_br  = ((class_q == C_BEQ) && zero) || ((class_q == C_BNE) && !zero);
          retire = is_br;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (class_q == C_STORE);
          retire   = rdy && (class_q == C_STORE);
        end
        S_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = (class_q == C_LOAD);
          retire     = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem.mem_req  = mem_req;
  assign mem.mem_we   = mem_we;
  assign mem.addr_sel = addr_sel;

  perf_counter #(.W(32)) u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (retire),
    .cnt   (retire_cnt)
  );
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench: every cycle's strobes are predicted from
// the instruction's class, wait counts and zero flag.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        zero = 1'b0;
  logic        ir_we, pc_we, pc_br, alu_src, reg_we, mem_to_reg, retire, illegal;
  logic [1:0]  alu_op;
  logic [31:0] retire_cnt;
  logic [31:0] model_cnt = '0;
  logic [12:0] obs;
  int          n_cmp = 0;
  int          n_bad = 0;

  multicycle_ctrl_if mif();

  multicycle_ctrl dut (
    .clk(clk), .n_rst(n_rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem(mif.master), .ir_we(ir_we), .pc_we(pc_we), .pc_br(pc_br),
    .alu_src(alu_src), .alu_op(alu_op), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .retire(retire), .illegal(illegal), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {mif.mem_req, mif.mem_we, mif.addr_sel, ir_we, pc_we, pc_br,
                alu_src, alu_op, reg_we, mem_to_reg, retire, illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ev(input int req, we, as, ir, pcw, pcb,
                                     src, op, rw, m2r, ret, ill);
    return {req[0], we[0], as[0], ir[0], pcw[0], pcb[0], src[0], op[1:0],
            rw[0], m2r[0], ret[0], ill[0]};
  endfunction

  // One clock: drive inputs just after the edge, check at the falling edge.
  task automatic step(input string tag, input bit rdy, input bit z, input logic [12:0] exp);
    mif.mem_ready = rdy;
    zero = z;
    @(negedge clk);
    chk(tag, {19'd0, obs}, {19'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_strobes", {19'd0, obs}, 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_cnt = '0;
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input bit z,
                           input int fw, input int mw);
    bit is_r, is_i, is_ld, is_st, is_br, taken;
    int op;
    is_r  = (opc == 7'b0110011);
    is_i  = (opc == 7'b0010011);
    is_ld = (opc == 7'b0000011);
    is_st = (opc == 7'b0100011);
    is_br = (opc == 7'b1100011);
    opcode = opc;
    funct3 = f3;
    for (int k = 0; k < fw; k++) step("fetch_wait", 1'b0, z, ev(1,0,0,0,0,0,0,0,0,0,0,0));
    step("fetch", 1'b1, z, ev(1,0,0,1,1,0,0,0,0,0,0,0));
    step("decode", 1'($urandom_range(0,1)), z, 13'd0);
    // Scramble the instruction bits: the controller must rely on its latch.
    opcode = 7'($urandom);
    funct3 = 3'($urandom);
    if (!(is_r || is_i || is_ld || is_st || is_br)) begin
      for (int k = 0; k < 3; k++)
        step("trap", 1'($urandom_range(0,1)), z, ev(0,0,0,0,0,0,0,0,0,0,0,1));
      chk("trap_cnt", retire_cnt, model_cnt);
      return;
    end
    taken = is_br && ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z));
    op = is_br ? 1 : (is_ld || is_st) ? 0 : 2;
    step("exec", 1'($urandom_range(0,1)), z,
         ev(0,0,0,0,0,int'(taken),int'(is_i||is_ld||is_st),op,0,0,int'(is_br),0));
    if (is_br) model_cnt++;
    if (is_ld || is_st) begin
      for (int k = 0; k < mw; k++)
        step("mem_wait", 1'b0, z, ev(1,int'(is_st),1,0,0,0,0,0,0,0,0,0));
      step("mem", 1'b1, z, ev(1,int'(is_st),1,0,0,0,0,0,0,0,int'(is_st),0));
      if (is_st) model_cnt++;
    end
    if (is_r || is_i || is_ld) begin
      step("wb", 1'($urandom_range(0,1)), z, ev(0,0,0,0,0,0,0,0,1,int'(is_ld),1,0));
      model_cnt++;
    end
    chk("retire_cnt", retire_cnt, model_cnt);
  endtask

  function automatic logic [6:0] pick_opcode(input int sel);
    logic [6:0] v;
    case (sel)
      0: v = 7'b0110011;
      1: v = 7'b0010011;
      2: v = 7'b0000011;
      3: v = 7'b0100011;
      4: v = 7'b1100011;
      default: begin
        v = 7'($urandom);
        while (v == 7'b0110011 || v == 7'b0010011 || v == 7'b0000011 ||
               v == 7'b0100011 || v == 7'b1100011)
          v = 7'($urandom);
      end
    endcase
    return v;
  endfunction

  initial begin
    mif.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(7'b0110011, 3'd0, 1'b0, 0, 0);           // ADD
    chk("add_cnt1", retire_cnt, 32'd1);
    run_instr(7'b0000011, 3'd2, 1'b0, 2, 3);           // LW with waits
    run_instr(7'b1100011, 3'd0, 1'b1, 0, 0);           // BEQ taken
    run_instr(7'b1100011, 3'd1, 1'b1, 0, 0);           // BNE not taken
    run_instr(7'b1100011, 3'd4, 1'b0, 1, 0);           // other funct3
    run_instr(7'b0100011, 3'd2, 1'b0, 0, 1);           // SW
    run_instr(7'b0010011, 3'd0, 1'b1, 1, 0);           // ADDI

    // Counter wrap: preload all-ones while idling in FETCH.
    mif.mem_ready = 1'b0;
    force dut.u_cnt.cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.u_cnt.cnt_q;
    chk("preload", retire_cnt, 32'hFFFF_FFFF);
    model_cnt = 32'hFFFF_FFFF;
    run_instr(7'b0110011, 3'd0, 1'b0, 0, 0);
    chk("wrap", retire_cnt, 32'd0);

    // Reset in the middle of a stalled SW memory phase.
    opcode = 7'b0100011;
    step("sw_fetch", 1'b1, 1'b0, ev(1,0,0,1,1,0,0,0,0,0,0,0));
    step("sw_decode", 1'b0, 1'b0, 13'd0);
    step("sw_exec", 1'b0, 1'b0, ev(0,0,0,0,0,0,1,0,0,0,0,0));
    mif.mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_mem", {19'd0, obs}, {19'd0, ev(1,1,1,0,0,0,0,0,0,0,0,0)});
    #2 n_rst = 1'b0;
    #1 chk("rst_abort", {19'd0, obs}, 32'd0);
    chk("rst_abort_cnt", retire_cnt, 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_cnt = '0;
    step("post_rst_fetch", 1'b0, 1'b0, ev(1,0,0,0,0,0,0,0,0,0,0,0));

    // Unsupported opcode traps until reset.
    run_instr(7'b0110011, 3'd0, 1'b0, 0, 0);
    run_instr(7'b1111111, 3'd0, 1'b0, 0, 0);
    chk("trap_frozen", retire_cnt, 32'd1);
    do_reset();
    step("after_trap", 1'b0, 1'b0, ev(1,0,0,0,0,0,0,0,0,0,0,0));

    for (int n = 0; n < 200; n++) begin
      logic [6:0] opc;
      int sel;
      sel = ($urandom_range(0, 19) == 0) ? 5 : $urandom_range(0, 4);
      opc = pick_opcode(sel);
      run_instr(opc, 3'($urandom), 1'($urandom_range(0,1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
      if (sel == 5) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port opcode  input  7  instr[6:0] from the instruction register.
REQ-004 SHALL have port funct3  input  3  instr[14:12] from the instruction register.
REQ-005 SHALL have port zero  input  1  ALU result == 0.
REQ-006 SHALL have port mem_ready  input  1  shared memory completes the access this cycle.
REQ-007 SHALL have port mem_req  output  1  memory access request.
REQ-008 SHALL have port mem_we  output  1  write qualifier for mem_req.
REQ-009 SHALL have port addr_sel  output  1  memory address mux: 0=PC, 1=ALU result.
REQ-010 SHALL have port ir_we  output  1  instruction register load strobe.
REQ-011 SHALL have port pc_we  output  1  PC <= PC+4 strobe.
REQ-012 SHALL have port pc_br  output  1  PC <= branch target strobe.
REQ-013 SHALL have port alu_src  output  1  ALU operand 2: 0=rd2, 1=immediate.
REQ-014 SHALL have port alu_op  output  2  00 add, 01 branch-compare (sub), 10 funct decode.
REQ-015 SHALL have port reg_we  output  1  register-file write strobe.
REQ-016 SHALL have port mem_to_reg  output  1  writeback mux: 1=memory data.
REQ-017 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-018 SHALL have port illegal  output  1  sticky flag, set on unsupported opcode.
REQ-019 SHALL have port retire_cnt  output  32  retired-instruction count.

Function
REQ-020 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB, TRAP; all strobes are decoded from state (plus latched class), never from combinational opcode.
REQ-021 FETCH: mem_req=1, addr_sel=0, mem_we=0; stay while mem_ready=0; on mem_ready=1 assert ir_we and pc_we in that cycle and go to DECODE.
REQ-022 DECODE: latch the instruction class from opcode/funct3 into a register; R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011 go to EXEC; any other opcode goes to TRAP.
REQ-023 EXEC: R: alu_src=0, alu_op=10. I-ALU: alu_src=1, alu_op=10. LOAD/STORE: alu_src=1, alu_op=00. BRANCH: alu_src=0, alu_op=01.
REQ-024 EXEC next state: R/I-ALU go to WB; LOAD/STORE go to MEM; BRANCH goes to FETCH with retire=1.
REQ-025 Branch taken: pc_br=1 in EXEC iff (funct3=000 and zero=1) or (funct3=001 and zero=0); other funct3 values never branch but still retire.
REQ-026 MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE and 0 for LOAD; hold while mem_ready=0; on mem_ready=1 STORE goes to FETCH with retire=1, LOAD goes to WB.
REQ-027 WB: reg_we=1 for exactly one cycle; mem_to_reg=1 only for LOAD; then go to FETCH with retire=1.
REQ-028 Instruction latency: branch 3, store 4, R/I-ALU 4, load 5 cycles, each with zero wait states; every mem_ready=0 cycle in FETCH/MEM adds one cycle.
REQ-029 pc_we and pc_br SHALL never be asserted in the same cycle; reg_we SHALL never be asserted while mem_req=1.
REQ-030 TRAP: absorbing state; all strobes 0, illegal=1, no retire; only reset exits.
REQ-031 retire_cnt SHALL increment by 1 on each retire pulse and wrap from 0xFFFFFFFF to 0.
REQ-032 mem_ready asserted outside FETCH/MEM SHALL be ignored.

Reset
REQ-033 While n_rst=0: state=FETCH, latched class cleared, illegal=0, retire_cnt=0; all strobes 0 except mem_req, which follows FETCH once n_rst rises.
REQ-034 Reset asserted mid-instruction (including during a mem_ready wait) SHALL abort it immediately: no retire, no reg_we, no pc update.

Structure
REQ-035 A shared package riscv_pkg SHALL hold the opcode localparams, the state enum ctrl_state_t, the class enum instr_class_t and the alu_op encodings.
REQ-036 The retire counter SHALL be a separate sub-module perf_counter (32-bit, enable, async reset).

Verification
REQ-037 ADD (opcode 0110011), mem_ready=1 always -> states F,D,E,W; reg_we high in cycle 4 only; retire in cycle 4; retire_cnt=1.
REQ-038 LW with mem_ready low for 2 cycles in FETCH and 3 in MEM -> 10 cycles total; mem_to_reg=1 and reg_we=1 only in the final cycle.
REQ-039 BEQ with zero=1 -> pc_br=1 in cycle 3; BNE with zero=1 -> pc_br=0, retire=1 in cycle 3.
REQ-040 SW -> mem_we=1 with addr_sel=1 only in MEM; reg_we never asserted.
REQ-041 Opcode 1111111 -> TRAP, illegal=1 sticky, retire_cnt frozen; pulse n_rst -> FETCH, illegal=0.
REQ-042 Force retire_cnt to 0xFFFFFFFF, then retire one ADD -> 0x00000000; assert n_rst low during MEM of an SW -> no retire, no mem_we, state=FETCH.
